// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// guard-phase length and default bus widths.
package imem_loader_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Cycles spent in GUARD: the final write cycle plus one settling cycle.
    localparam int GUARD_CYCLES = 2;
    localparam int GUARD_CNT_W  = 2;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_GUARD = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams program words into the instruction
// memory at sequential addresses from 0, holds the processor in reset until
// the last word lands, then releases it. Writing past the top of memory
// latches an overflow error.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a running wrapping sum
// of all accepted words on the checksum output.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_data,
    output logic                  proc_reset,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow_err
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam logic [ADDR_WIDTH-1:0]  PTR_MAX    = '1;
    localparam logic [ADDR_WIDTH-1:0]  PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]    CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [GUARD_CNT_W-1:0] GUARD_LAST = GUARD_CNT_W'(GUARD_CYCLES - 1);
    localparam logic [GUARD_CNT_W-1:0] GUARD_ONE  = GUARD_CNT_W'(1);

    state_e                  state_q, state_d;
    logic [GUARD_CNT_W-1:0]  guard_q, guard_d;
    logic                    ready_q, ready_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    wren_q, wren_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    accept;

    // A word transfers only when the loader is ready; ready is only ever high in LOAD.
    assign accept = s_valid & ready_q;

    // State register and guard-phase counter.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q <= ST_LOAD;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
        end
    end

    // Next-state logic: last word goes to GUARD, an overrun word goes to ERROR.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (s_last) begin
                        state_d = ST_GUARD;
                        guard_d = '0;
                    end else if (ptr_q == PTR_MAX) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    guard_d = guard_q + GUARD_ONE;
                end
            end
            ST_RUN:   state_d = ST_RUN;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_LOAD;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        proc_reset   = (state_q != ST_RUN);
        load_done    = (state_q == ST_RUN);
        overflow_err = (state_q == ST_ERROR);
    end

    // Datapath next values: pointer/count advance per accept, write port mirrors the accept one cycle later.
    always_comb begin
        ready_d = (state_d == ST_LOAD);
        ptr_d   = ptr_q;
        count_d = count_q;
        wren_d  = accept;
        addr_d  = addr_q;
        data_d  = data_q;
        if (accept) begin
            ptr_d   = ptr_q + PTR_ONE;
            count_d = count_q + CNT_ONE;
            addr_d  = ptr_q;
            data_d  = s_data;
        end
    end

    // Datapath registers, including the registered memory write port.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            ready_q <= 1'b0;
            ptr_q   <= '0;
            count_q <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            ready_q <= ready_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign s_ready    = ready_q;
    assign imem_wren  = wren_q;
    assign imem_addr  = addr_q;
    assign imem_data  = data_q;
    assign word_count = count_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    // Wrapping sum of accepted words, next value.
    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            sum_d = sum_q + s_data;
        end
    end

    // Wrapping sum register.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one default-width instance and one with a
// 4-word memory share the same load stream and reset.
module tb_imem_loader;

    localparam int AW_A = 12;
    localparam int AW_B = 2;
    localparam int DW   = 32;

    logic              clock = 1'b0;
    logic              ctrl_reset = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic [DW-1:0]     s_data = '0;

    logic              a_ready, a_wren, a_proc_reset, a_load_done, a_overflow;
    logic [AW_A-1:0]   a_addr;
    logic [DW-1:0]     a_data;
    logic [AW_A:0]     a_count;
    logic              b_ready, b_wren, b_proc_reset, b_load_done, b_overflow;
    logic [AW_B-1:0]   b_addr;
    logic [DW-1:0]     b_data;
    logic [AW_B:0]     b_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DW-1:0]     a_checksum, b_checksum;
`endif

    int checks = 0;
    int errors = 0;

    int unsigned   a_addr_log[$];
    logic [DW-1:0] a_data_log[$];
    int unsigned   b_addr_log[$];
    logic [DW-1:0] b_data_log[$];
    logic [DW-1:0] exp_data[8];

    imem_loader #(.ADDR_WIDTH(AW_A), .DATA_WIDTH(DW)) dut_a (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .s_valid(s_valid), .s_ready(a_ready), .s_data(s_data), .s_last(s_last),
        .imem_wren(a_wren), .imem_addr(a_addr), .imem_data(a_data),
        .proc_reset(a_proc_reset), .load_done(a_load_done),
        .word_count(a_count), .overflow_err(a_overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(a_checksum)
`endif
    );

    imem_loader #(.ADDR_WIDTH(AW_B), .DATA_WIDTH(DW)) dut_b (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .s_valid(s_valid), .s_ready(b_ready), .s_data(s_data), .s_last(s_last),
        .imem_wren(b_wren), .imem_addr(b_addr), .imem_data(b_data),
        .proc_reset(b_proc_reset), .load_done(b_load_done),
        .word_count(b_count), .overflow_err(b_overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(b_checksum)
`endif
    );

    always #5 clock = ~clock;

    // Record every memory write seen by either instance.
    always @(negedge clock) begin
        if (a_wren) begin
            a_addr_log.push_back(int'(a_addr));
            a_data_log.push_back(a_data);
        end
        if (b_wren) begin
            b_addr_log.push_back(int'(b_addr));
            b_data_log.push_back(b_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [DW-1:0] d, input logic l);
        @(negedge clock);
        s_valid = v;
        s_data  = d;
        s_last  = l;
    endtask

    task automatic do_reset();
        @(negedge clock);
        ctrl_reset = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clock);
        a_addr_log.delete(); a_data_log.delete();
        b_addr_log.delete(); b_data_log.delete();
        ctrl_reset = 1'b1;
    endtask

    task automatic check_a_writes(input string tag, input int n);
        check({tag, "_a_nwrites"}, 64'(a_addr_log.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            check({tag, "_a_addr"}, (i < a_addr_log.size()) ? 64'(a_addr_log[i]) : 64'hx, 64'(i));
            check({tag, "_a_data"}, (i < a_data_log.size()) ? 64'(a_data_log[i]) : 64'hx, 64'(exp_data[i]));
        end
    endtask

    task automatic check_b_writes(input string tag, input int n);
        check({tag, "_b_nwrites"}, 64'(b_addr_log.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            check({tag, "_b_addr"}, (i < b_addr_log.size()) ? 64'(b_addr_log[i]) : 64'hx, 64'(i));
            check({tag, "_b_data"}, (i < b_data_log.size()) ? 64'(b_data_log[i]) : 64'hx, 64'(exp_data[i]));
        end
    endtask

    initial begin
        // Reset state, held from time 0.
        @(negedge clock);
        check("rst_ready",      64'(a_ready),      64'd0);
        check("rst_wren",       64'(a_wren),       64'd0);
        check("rst_addr",       64'(a_addr),       64'd0);
        check("rst_data",       64'(a_data),       64'd0);
        check("rst_count",      64'(a_count),      64'd0);
        check("rst_proc_reset", 64'(a_proc_reset), 64'd1);
        check("rst_load_done",  64'(a_load_done),  64'd0);
        check("rst_overflow",   64'(a_overflow),   64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("rst_checksum",   64'(a_checksum),   64'd0);
`endif
        ctrl_reset = 1'b1;
        @(negedge clock);
        check("ready_rise", 64'(a_ready), 64'd1);

        // Basic 4-word program, last on 0x44; the 4-word instance fills exactly.
        beat(1'b1, 32'h11, 1'b0);
        beat(1'b1, 32'h22, 1'b0);
        beat(1'b1, 32'h33, 1'b0);
        beat(1'b1, 32'h44, 1'b1);
        beat(1'b0, 32'h0, 1'b0);
        check("last_wren",       64'(a_wren),       64'd1);
        check("last_addr",       64'(a_addr),       64'd3);
        check("last_data",       64'(a_data),       64'h44);
        check("last_ready_low",  64'(a_ready),      64'd0);
        check("guard0_proc_rst", 64'(a_proc_reset), 64'd1);
        beat(1'b0, 32'h0, 1'b0);
        check("guard1_proc_rst", 64'(a_proc_reset), 64'd1);
        check("guard1_wren",     64'(a_wren),       64'd0);
        check("guard1_done",     64'(a_load_done),  64'd0);
        beat(1'b0, 32'h0, 1'b0);
        check("run_proc_rst",    64'(a_proc_reset), 64'd0);
        check("run_done",        64'(a_load_done),  64'd1);
        check("run_count",       64'(a_count),      64'd4);
        check("b_full_done",     64'(b_load_done),  64'd1);
        check("b_full_overflow", 64'(b_overflow),   64'd0);
        check("b_full_count",    64'(b_count),      64'd4);
        exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h33; exp_data[3] = 32'h44;
        check_a_writes("basic", 4);
        check_b_writes("basic", 4);
        // Stream activity in RUN is ignored.
        beat(1'b1, 32'h55, 1'b0);
        beat(1'b1, 32'h66, 1'b1);
        beat(1'b0, 32'h0, 1'b0);
        beat(1'b0, 32'h0, 1'b0);
        check("run_ignore_count", 64'(a_count),           64'd4);
        check("run_ignore_ready", 64'(a_ready),           64'd0);
        check("run_ignore_done",  64'(a_load_done),       64'd1);
        check("run_ignore_nwr",   64'(a_addr_log.size()), 64'd4);

        // Valid toggled every other cycle, 3 words.
        do_reset();
        beat(1'b1, 32'hA1, 1'b0);
        beat(1'b0, 32'h0, 1'b0);
        beat(1'b1, 32'hA2, 1'b0);
        beat(1'b0, 32'h0, 1'b0);
        beat(1'b1, 32'hA3, 1'b1);
        repeat (4) beat(1'b0, 32'h0, 1'b0);
        exp_data[0] = 32'hA1; exp_data[1] = 32'hA2; exp_data[2] = 32'hA3;
        check_a_writes("gappy", 3);
        check("gappy_count", 64'(a_count),     64'd3);
        check("gappy_done",  64'(a_load_done), 64'd1);

        // Overflow on the 4-word instance: 5 words, no last.
        do_reset();
        beat(1'b1, 32'hB0, 1'b0);
        beat(1'b1, 32'hB1, 1'b0);
        beat(1'b1, 32'hB2, 1'b0);
        beat(1'b1, 32'hB3, 1'b0);
        beat(1'b1, 32'hB4, 1'b0);
        repeat (3) beat(1'b0, 32'h0, 1'b0);
        exp_data[0] = 32'hB0; exp_data[1] = 32'hB1; exp_data[2] = 32'hB2; exp_data[3] = 32'hB3;
        check_b_writes("ovf", 4);
        check("ovf_flag",      64'(b_overflow),   64'd1);
        check("ovf_proc_rst",  64'(b_proc_reset), 64'd1);
        check("ovf_done",      64'(b_load_done),  64'd0);
        check("ovf_ready",     64'(b_ready),      64'd0);
        check("ovf_count",     64'(b_count),      64'd4);
        check("ovf_wren_idle", 64'(b_wren),       64'd0);
        check("wide_count5",   64'(a_count),      64'd5);
        check("wide_no_ovf",   64'(a_overflow),   64'd0);
        check("wide_ready",    64'(a_ready),      64'd1);

        // Reset pulse mid-load, then a fresh 3-word load.
        do_reset();
        beat(1'b1, 32'hC0, 1'b0);
        beat(1'b1, 32'hC1, 1'b0);
        @(negedge clock);
        check("midload_wren_pre", 64'(a_wren), 64'd1);
        s_valid = 1'b0;
        ctrl_reset = 1'b0;
        #1;
        check("async_wren",  64'(a_wren),  64'd0);
        check("async_count", 64'(a_count), 64'd0);
        check("async_ready", 64'(a_ready), 64'd0);
        check("async_addr",  64'(a_addr),  64'd0);
        @(negedge clock);
        a_addr_log.delete(); a_data_log.delete();
        b_addr_log.delete(); b_data_log.delete();
        ctrl_reset = 1'b1;
        beat(1'b1, 32'hD0, 1'b0);
        beat(1'b1, 32'hD1, 1'b0);
        beat(1'b1, 32'hD2, 1'b1);
        repeat (4) beat(1'b0, 32'h0, 1'b0);
        exp_data[0] = 32'hD0; exp_data[1] = 32'hD1; exp_data[2] = 32'hD2;
        check_a_writes("reload", 3);
        check("reload_count", 64'(a_count),     64'd3);
        check("reload_done",  64'(a_load_done), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrapping checksum.
        do_reset();
        beat(1'b1, 32'hFFFF_FFFF, 1'b0);
        beat(1'b1, 32'h0000_0002, 1'b1);
        beat(1'b0, 32'h0, 1'b0);
        check("checksum_a", 64'(a_checksum), 64'd1);
        check("checksum_b", 64'(b_checksum), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning the instruction memory word-address width (4096 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width.
REQ-003 clock  input  1  single clock; all state on its rising edge.
REQ-004 ctrl_reset  input  1  asynchronous, active-low reset.
REQ-005 s_valid  input  1  load-stream word valid.
REQ-006 s_ready  output  1  loader accepts a word this cycle.
REQ-007 s_data  input  DATA_WIDTH  instruction word.
REQ-008 s_last  input  1  marks the final word of the program.
REQ-009 imem_wren  output  1  instruction memory write enable.
REQ-010 imem_addr  output  ADDR_WIDTH  instruction memory write address.
REQ-011 imem_data  output  DATA_WIDTH  instruction memory write data.
REQ-012 proc_reset  output  1  active-high hold-in-reset for processor/regfile, held until load completes.
REQ-013 load_done  output  1  program loaded, processor running.
REQ-014 word_count  output  ADDR_WIDTH+1  number of words written.
REQ-015 overflow_err  output  1  program exceeded memory depth.

Function
REQ-016 Accept occurs on a rising edge where s_valid and s_ready are both high; s_data/s_last are sampled only then.
REQ-017 FSM states: LOAD, GUARD, RUN, ERROR; LOAD is entered from reset.
REQ-018 LOAD: s_ready=1; each accept increments the write pointer and word_count by 1.
REQ-019 Write latency: a word accepted at edge N drives imem_wren=1, imem_addr=pointer value at accept, imem_data=s_data throughout cycle N..N+1 (registered); imem_wren=0 in every other cycle.
REQ-020 Addresses are written sequentially from 0 with no gaps; s_valid low inserts idle cycles without side effects.
REQ-021 Accept with s_last=1 in LOAD: transition to GUARD; s_ready=0 from the next cycle.
REQ-022 GUARD lasts exactly 2 cycles (final write cycle plus one guard cycle), then RUN.
REQ-023 RUN: proc_reset=0, load_done=1, s_ready=0; RUN is held until reset, and s_valid is ignored.
REQ-024 Accept with pointer == 2^ADDR_WIDTH-1 and s_last=0: the word is written, then transition to ERROR.
REQ-025 Accept with pointer == 2^ADDR_WIDTH-1 and s_last=1 is legal: GUARD, then RUN.
REQ-026 ERROR: overflow_err=1, s_ready=0, proc_reset=1, load_done=0; held until reset.
REQ-027 proc_reset=1 in LOAD, GUARD and ERROR.
REQ-028 A zero-length program is not supported; the first accepted word always writes address 0.

Reset
REQ-029 ctrl_reset low asynchronously forces LOAD, pointer=0, word_count=0, imem_wren=0, imem_addr=0, imem_data=0, proc_reset=1, load_done=0, overflow_err=0, s_ready=0.
REQ-030 s_ready rises on the first rising edge after ctrl_reset deasserts.
REQ-031 Reset mid-load or in RUN discards progress; the next load restarts at address 0.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN: when defined, output checksum (DATA_WIDTH) SHALL hold the wrapping modulo-2^DATA_WIDTH sum of all accepted words; it resets to 0 and is updated on the cycle after each accept.
REQ-033 When IMEM_LOADER_CHECKSUM_EN is undefined, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Shared package imem_loader_pkg SHALL hold the FSM state enum, the GUARD_CYCLES=2 constant and the default width constants.
REQ-035 No sub-module; the FSM, pointer and counters reside in imem_loader.

Verification
REQ-036 Reset, then 4 words 0x11,0x22,0x33,0x44 with last on 0x44 -> writes to addr 0..3 in order, word_count=4, proc_reset falls 2 cycles after the last write cycle begins, load_done=1.
REQ-037 s_valid toggled every other cycle for 3 words -> exactly 3 writes, no duplicate or skipped addresses.
REQ-038 ADDR_WIDTH=2, 5 words with no last -> addresses 0..3 written, overflow_err=1, proc_reset stays 1, 5th word never accepted.
REQ-039 ADDR_WIDTH=2, 4 words with last on the 4th -> RUN, overflow_err=0.
REQ-040 ctrl_reset pulsed after 2 of 5 words, then reload of 3 words -> writes restart at addr 0, word_count=3.
REQ-041 With IMEM_LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x2 -> checksum=0x1.
